// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } spi_state_e;

    localparam int SPI_DEFAULT_WIDTH = 8;

    // Bus mode; only CPOL=0/CPHA=0 timing is implemented.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser, clears to zero on reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first, full-duplex SPI initiator: one DATA_WIDTH word per start.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = SPI_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_clk,
    output logic                  mosi,
    output logic                  cs_n,
    input  logic                  miso
);

    localparam int PH_W = $clog2(CLK_DIV);
    localparam int BW   = $clog2(DATA_WIDTH);
    localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  spi_clk_q, spi_clk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  miso_s;
    logic                  ph_end;
    logic                  in_xfer;

    sync2 #(.WIDTH(1)) u_miso_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (miso),
        .q_o    (miso_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            last_q    <= 1'b0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            spi_clk_q <= CPOL;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            spi_clk_q <= spi_clk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        last_d    = last_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        ph_end    = (ph_q == '0);

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SETUP;
                    tx_d    = tx_data;
                    bit_d   = BIT_LAST;
                    last_d  = 1'b0;
                end
            end
            SETUP: if (ph_end) state_d = HIGH;
            HIGH: begin
                if (ph_end) begin
                    state_d = LOW;
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso_s};
                    // Advance mosi on the falling edge; after the last bit LOW is just cs_n hold.
                    if (bit_q != '0) begin
                        tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        bit_d = bit_q - BW'(1);
                    end else begin
                        last_d = 1'b1;
                    end
                end
            end
            LOW: begin
                if (ph_end) begin
                    if (last_q) begin
                        state_d   = DONE;
                        tx_d      = '0;
                        rx_data_d = rx_sh_q;
                    end else begin
                        state_d = HIGH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) ph_d = PH_RELOAD;
        else if (!ph_end)       ph_d = ph_q - PH_W'(1);
        else                    ph_d = ph_q;

        // Outputs are registered from the next state so every pin comes straight off a flop.
        in_xfer   = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW);
        spi_clk_d = (state_d == HIGH) ^ CPOL;
        cs_n_d    = !in_xfer;
        busy_d    = in_xfer;
        done_d    = (state_d == DONE);
    end

    assign spi_clk = spi_clk_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign mosi    = tx_q[DATA_WIDTH-1];
    assign rx_data = rx_data_q;

endmodule
